// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//   IF-stage fetch PC owner and IF/ID pipeline register. Consumes the EX-stage
//   redirect pair (PcSel/BrPC), honours load-use stalls and instruction-memory
//   wait states, and drives the ID/EX flush that squashes wrong-path work.
//
//   Optional feature macro: BR_MISALIGN_TRAP_EN
//     defined   : a redirect whose target has BrPC[1:0]!=0 goes to TRAP_VEC
//                 and raises MisalignTrap for exactly one cycle.
//     undefined : BrPC[1:0] are forced to 2'b00 on load; MisalignTrap is 0.
//
// Ports
//   clk          in   1     clock, rising edge
//   reset        in   1     asynchronous, active-low reset
//   PcSel        in   1     redirect request from EX
//   BrPC         in   32    redirect target (bits above PC_W ignored)
//   Stall        in   1     load-use stall: hold PC, IF/ID and state
//   ImemReady    in   1     imem data valid for Pc this cycle
//   ImemData     in   32    imem read data at Pc
//   Pc           out  PC_W  current fetch address
//   IfId_Pc      out  PC_W  PC of instruction held in IF/ID
//   IfId_Instr   out  32    instruction held in IF/ID
//   IfId_Valid   out  1     IF/ID holds a real (non-bubble) instruction
//   FlushIdEx    out  1     combinational: load a bubble into ID/EX
//   MisalignTrap out  1     registered one-cycle pulse (macro build only)
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter int unsigned     PC_W      = 9,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
  parameter logic [PC_W-1:0] TRAP_VEC  = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Stall,
  input  logic            ImemReady,
  input  logic [31:0]     ImemData,
  output logic [PC_W-1:0] Pc,
  output logic [PC_W-1:0] IfId_Pc,
  output logic [31:0]     IfId_Instr,
  output logic            IfId_Valid,
  output logic            FlushIdEx,
  output logic            MisalignTrap
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PC_W-1:0] pc_p0,         pc_nxt;
  logic [PC_W-1:0] ifid_pc_p1,    ifid_pc_nxt;
  logic [31:0]     ifid_instr_p1, ifid_instr_nxt;
  logic            vld_p1,        vld_nxt;
  logic            redirect;

  // Address bits above the fetch window never influence the PC.
  logic unused_bits;
  assign unused_bits = ^{BrPC[31:PC_W], TRAP_VEC};

  // Sequential fetch advance; wraps modulo 2^PC_W with no flag.
  function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

  // Where a redirect lands. Misaligned targets either trap or are word-aligned.
  function automatic logic [PC_W-1:0] redirect_target(input logic [PC_W-1:0] br);
`ifdef BR_MISALIGN_TRAP_EN
    if (br[1:0] != 2'b00) return TRAP_VEC;
    return br;
`else
    return br & ~PC_W'(3);
`endif
  endfunction

  // PcSel arriving while the unit is still booting is not acted on.
  assign redirect  = PcSel && (state != ST_BOOT);
  assign FlushIdEx = redirect;

`ifdef BR_MISALIGN_TRAP_EN
  logic trap_nxt, trap_p1;
  assign trap_nxt = redirect && (BrPC[1:0] != 2'b00);
`endif

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc_p0;
    ifid_pc_nxt    = ifid_pc_p1;
    ifid_instr_nxt = ifid_instr_p1;
    vld_nxt        = vld_p1;

    unique case (state)
      ST_BOOT: begin
        // One settling cycle: nothing committed, IF/ID shows a bubble.
        ifid_instr_nxt = NOP_INSTR;
        vld_nxt        = 1'b0;
        state_nxt      = ST_FETCH;
      end
      default: begin
        // FETCH and WAIT share one decision ladder; they differ only in
        // which state is recorded while imem is not ready.
        if (redirect) begin
          // The wrong-path word at the old Pc is dropped even if ready.
          pc_nxt         = redirect_target(BrPC[PC_W-1:0]);
          ifid_instr_nxt = NOP_INSTR;
          vld_nxt        = 1'b0;
          state_nxt      = ST_FETCH;
        end else if (Stall) begin
          state_nxt = state;
        end else if (!ImemReady) begin
          ifid_instr_nxt = NOP_INSTR;
          vld_nxt        = 1'b0;
          state_nxt      = ST_WAIT;
        end else begin
          ifid_pc_nxt    = pc_p0;
          ifid_instr_nxt = ImemData;
          vld_nxt        = 1'b1;
          pc_nxt         = pc_incr(pc_p0);
          state_nxt      = ST_FETCH;
        end
      end
    endcase
  end

  // ---- IF stage: fetch PC and control state ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_BOOT;
      pc_p0 <= '0;
    end else begin
      state <= state_nxt;
      pc_p0 <= pc_nxt;
    end
  end

  // ---- IF/ID boundary ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_pc_p1    <= '0;
      ifid_instr_p1 <= NOP_INSTR;
      vld_p1        <= 1'b0;
    end else begin
      ifid_pc_p1    <= ifid_pc_nxt;
      ifid_instr_p1 <= ifid_instr_nxt;
      vld_p1        <= vld_nxt;
    end
  end

`ifdef BR_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) trap_p1 <= 1'b0;
    else        trap_p1 <= trap_nxt;
  end
  assign MisalignTrap = trap_p1;
`else
  assign MisalignTrap = 1'b0;
`endif

  assign Pc         = pc_p0;
  assign IfId_Pc    = ifid_pc_p1;
  assign IfId_Instr = ifid_instr_p1;
  assign IfId_Valid = vld_p1;

endmodule
